sm_display_scan_ctrl: RTL
=========================

SM_DISPLAY_SCAN_CTRL -- requirements
Module: sm_display_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 50000: clock cycles each digit is driven per visit (legal >= 1).
REQ-002 SHALL have parameter BLANK, default 500: dead-time cycles before each digit visit, all digits off (legal >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  scan enable; 0 forces display dark and scan restart.
REQ-006 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-007 SHALL have port upd_valid  input  1  new display value offered.
REQ-008 SHALL have port upd_value  input  12  three hex digits; [3:0] is digit 0, the least significant.
REQ-009 SHALL have port upd_ready  output  1  pending slot empty; update accepted when valid && ready.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dig_n  output  3  digit enables, active-low, one-hot-low; bit i drives digit i.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full 3-digit scan.

Function
REQ-013 SHALL hold an active register (displayed, 12 bit) and a pending register (12 bit plus pending flag).
REQ-014 SHALL drive upd_ready = ~pending_flag, and load pending on valid && ready, setting the flag.
REQ-015 SHALL copy pending to active and clear the flag only at a frame boundary, i.e. the cycle frame_done is asserted, so a frame never shows mixed values.
REQ-016 SHALL handle an accept in the same cycle as a frame boundary by loading pending only, applying it at the next boundary.
REQ-017 SHALL run FSM states BLANK and ON, with a cycle counter and a digit index of 0..2.
REQ-018 In BLANK, SHALL drive seg = 7'h7F and dig_n = 3'b111 for exactly BLANK cycles, then go to ON.
REQ-019 In ON, SHALL drive dig_n low only at the current index and seg from the decoded nibble, for exactly DWELL cycles, then go to BLANK.
REQ-020 On each ON->BLANK transition, SHALL advance the index 0->1->2->0.
REQ-021 SHALL pulse frame_done for the single cycle in which the index wraps 2->0.
REQ-022 SHALL make the frame period exactly 3*(BLANK+DWELL) cycles.
REQ-023 SHALL decode nibbles to standard hex glyphs, active-low, with 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A, b, C, d, E, F forms.
REQ-024 When lz_en=1, SHALL blank digit 2 (seg 7'h7F, dig_n still asserted) if its nibble is 0.
REQ-025 When lz_en=1, SHALL blank digit 1 if digits 2 and 1 are both 0.
REQ-026 SHALL never blank digit 0.
REQ-027 SHALL register all outputs, with no combinational path from inputs to seg, dig_n or frame_done.
REQ-028 When en=0, SHALL hold state BLANK, counter 0, index 0, seg = 7'h7F, dig_n = 3'b111 and frame_done = 0.
REQ-029 When en=0, the update handshake SHALL remain operational.
REQ-030 When en=0 and the flag is set, SHALL apply pending to active immediately, on the next cycle.
REQ-031 On en rising, SHALL restart the scan at BLANK of digit 0.

Reset
REQ-032 While rst_n=0, SHALL asynchronously force seg = 7'h7F, dig_n = 3'b111, frame_done = 0, upd_ready = 1.
REQ-033 While rst_n=0, SHALL also force active = 12'h000, pending flag = 0, state BLANK, counter 0, index 0.
REQ-034 On rst_n deassertion, SHALL begin the scan on the first clock edge when en=1.
REQ-035 Reset mid-frame or mid-handshake SHALL discard all pending data.

Verification (DWELL=4, BLANK=2)
REQ-036 Reset release, en=1, no update -> cycles 0-1 dig_n=111; 2-5 dig_n=110 with seg=1000000; digit 1 at 8-11; digit 2 at 14-17; frame_done one pulse every 18 cycles.
REQ-037 Offer 12'h3A5 mid-frame -> upd_ready drops the next cycle; display unchanged until frame_done; next frame shows 5, A, 3; upd_ready returns to 1.
REQ-038 Hold upd_valid with a second value while pending -> not accepted (ready=0); accepted the cycle after the boundary; applied one frame later.
REQ-039 lz_en=1, value 12'h007 -> digit 0 shows 7; digits 1 and 2 seg=7F. Value 12'h070 -> digit 1 shows 7, digit 2 blank, digit 0 shows 0.
REQ-040 Deassert en during ON of digit 1 -> next cycle dark and index 0; re-assert -> exactly 2 blank cycles then digit 0.
REQ-041 Assert rst_n=0 asynchronously mid-ON with pending set -> outputs dark immediately without a clock; after release, active=000 and upd_ready=1.

Source files
------------

// File: rtl/sm_display_scan_ctrl_if.sv
// Update handshake and registered display outputs of the 3-digit scan controller.
// master = producer/observer side, slave = the controller.
interface sm_display_scan_ctrl_if;
    logic        upd_valid;
    logic [11:0] upd_value;
    logic        upd_ready;
    logic [6:0]  seg;
    logic [2:0]  dig_n;
    logic        frame_done;

    modport master (
        output upd_valid, upd_value,
        input  upd_ready, seg, dig_n, frame_done
    );

    modport slave (
        input  upd_valid, upd_value,
        output upd_ready, seg, dig_n, frame_done
    );
endinterface

// File: rtl/sm_display_scan_ctrl.sv
// 3-digit multiplexed 7-segment scanner; outputs registered, frame = 3*(BLANK+DWELL) cycles.
// One-deep pending slot (upd_ready = slot empty), applied only at frame boundary or while disabled.
module sm_display_scan_ctrl #(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   lz_en,
    sm_display_scan_ctrl_if.slave  bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

    typedef enum logic {S_BLANK, S_ON} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   active;
    logic [11:0]   pend;
    logic          pend_flag;
    logic [6:0]    seg_q;
    logic [2:0]    dig_n_q;
    logic          frame_done_q;

    assign bus.upd_ready  = ~pend_flag;
    assign bus.seg        = seg_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_done = frame_done_q;

    function automatic logic [6:0] digit_seg(input logic [11:0] val, input logic [1:0] i,
                                             input logic lz);
        logic [3:0] nib;
        logic       blank;
        logic [6:0] g;
        nib   = val[3:0];
        blank = 1'b0;
        case (i)
            2'd1: begin
                nib   = val[7:4];
                blank = lz && (val[11:4] == 8'h00);
            end
            2'd2: begin
                nib   = val[11:8];
                blank = lz && (val[11:8] == 4'h0);
            end
            default: nib = val[3:0];
        endcase
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return blank ? 7'h7F : g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BLANK;
            cnt          <= '0;
            idx          <= 2'd0;
            active       <= 12'h000;
            pend         <= 12'h000;
            pend_flag    <= 1'b0;
            seg_q        <= 7'h7F;
            dig_n_q      <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Accept and apply are exclusive: accept needs an empty slot, apply a full one.
            if (bus.upd_valid && !pend_flag) begin
                pend      <= bus.upd_value;
                pend_flag <= 1'b1;
            end
            if (!en) begin
                state   <= S_BLANK;
                cnt     <= '0;
                idx     <= 2'd0;
                seg_q   <= 7'h7F;
                dig_n_q <= 3'b111;
                if (pend_flag) begin
                    active    <= pend;
                    pend_flag <= 1'b0;
                end
            end else if (state == S_BLANK) begin
                if (cnt == BL_LAST) begin
                    state   <= S_ON;
                    cnt     <= '0;
                    seg_q   <= digit_seg(active, idx, lz_en);
                    dig_n_q <= ~(3'b001 << idx);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                if (cnt == DW_LAST) begin
                    state   <= S_BLANK;
                    cnt     <= '0;
                    seg_q   <= 7'h7F;
                    dig_n_q <= 3'b111;
                    if (idx == 2'd2) begin
                        idx          <= 2'd0;
                        frame_done_q <= 1'b1;
                        if (pend_flag) begin
                            active    <= pend;
                            pend_flag <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end else begin
                    cnt   <= cnt + CW'(1);
                    seg_q <= digit_seg(active, idx, lz_en);
                end
            end
        end
    end
endmodule
